// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier and its controller.
//   WIDTH : operand width (product is 2*WIDTH bits)
//   CNT_W : iteration counter width, 2**CNT_W must exceed WIDTH
//   state_e : multiplier FSM state encoding (11 is illegal)
package mul_pkg;
  localparam int WIDTH = 64;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;
endpackage

// File: rtl/mul_step.sv
// One shift-add iteration of the unsigned multiplier.
//   result_in_i  : current {accumulator, remaining multiplier bits}
//   mcand_i      : latched multiplicand
//   result_out_o : value after conditional add and right shift by one
module mul_step #(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic [2*WIDTH-1:0] result_in_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] result_out_o
);
  logic [WIDTH:0] sum;

  // The extra sum bit carries into the MSB once the word shifts right.
  always_comb begin
    sum          = {1'b0, result_in_i[2*WIDTH-1:WIDTH]}
                 + (result_in_i[0] ? {1'b0, mcand_i} : {(WIDTH+1){1'b0}});
    result_out_o = {sum, result_in_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH unsigned shift-add multiplier.
// Runs a fixed WIDTH iterations per operation, then holds the product
// and op_done until op_clear or reset.
//   clk, reset   : clock, synchronous active-high reset
//   op_start     : start request, only honoured in IDLE
//   op_clear     : abort/clear, wins over everything but reset
//   multiplicand : operand A, latched on start
//   multiplier   : operand B, latched on start (into the low result half)
//   op_done      : product valid
//   result       : product (partial while busy)
module seq_multiplier #(
  parameter int WIDTH = mul_pkg::WIDTH,
  parameter int CNT_W = mul_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);
  import mul_pkg::*;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   result_q;
  logic [2*WIDTH-1:0]   result_d;
  logic                 done_q;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .result_in_i  (result_q),
    .mcand_i      (mcand_q),
    .result_out_o (result_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (op_clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_start) begin
            mcand_q  <= multiplicand;
            result_q <= {{WIDTH{1'b0}}, multiplier};
            cnt_q    <= '0;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          result_q <= result_d;
          cnt_q    <= cnt_q + 1'b1;
          // Counter enters this edge at WIDTH-1: this is the last of
          // WIDTH iterations, so the product is final after this edge.
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: ;
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          result_q <= '0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign op_done = done_q;
  assign result  = result_q;
endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         op_start = 1'b0;
  logic         op_clear = 1'b0;
  logic [63:0]  a = '0;
  logic [63:0]  b = '0;
  logic         op_done;
  logic [127:0] result;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  seq_multiplier dut (
    .clk          (clk),
    .reset        (reset),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (a),
    .multiplier   (b),
    .op_done      (op_done),
    .result       (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: product computed arithmetically at start, then
  // a fixed count of 64 busy cycles before it becomes visible.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  int           m_left = 0;
  logic [127:0] m_prod = '0;

  always @(posedge clk) begin
    if (reset || op_clear) begin
      m_busy = 1'b0; m_done = 1'b0;
    end else if (!m_busy && !m_done) begin
      if (op_start) begin
        m_prod = {64'b0, a} * {64'b0, b};
        m_busy = 1'b1;
        m_left = 64;
      end
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_done", {127'b0, op_done}, {127'b0, m_done});
      if (m_done) chk("model_result", result, m_prod);
      else if (!m_busy) chk("idle_result", result, '0);
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!op_done && n < 200);
  endtask

  task automatic start_op(input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    a = av; b = bv; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [63:0] av, input logic [63:0] bv,
                        input logic [127:0] exp);
    int n;
    start_op(av, bv);
    wait_done(n);
    chk({nm, "_latency"}, 128'(n), 128'd64);
    chk(nm, result, exp);
  endtask

  task automatic do_clear();
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk); #1;
    op_clear = 1'b0;
    chk("clear_result", result, '0);
    chk("clear_done", {127'b0, op_done}, '0);
  endtask

  initial begin
    int n;
    bit saw;
    // Reset held with op_start asserted.
    op_start = 1'b1; a = 64'd2; b = 64'd3;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_done", {127'b0, op_done}, '0);
    chk("rst_result", result, '0);
    @(negedge clk);
    reset = 1'b0;                 // start is sampled on the next edge
    @(posedge clk); #1;
    op_start = 1'b0;
    wait_done(n);
    chk("rst_start_latency", 128'(n), 128'd64);
    chk("rst_start_result", result, 128'd6);
    do_clear();

    // 5*6, held 20 cycles, then cleared.
    run_op("p5x6", 64'd5, 64'd6, 128'd30);
    repeat (20) begin
      @(negedge clk);
      chk("hold_done", {127'b0, op_done}, 128'd1);
      chk("hold_result", result, 128'd30);
    end
    do_clear();

    run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    do_clear();
    run_op("zero", 64'd20, 64'd0, 128'd0);
    do_clear();
    run_op("fact19", 64'd1, 64'd121645100408832000, 128'd121645100408832000);
    do_clear();

    // Abort mid-operation.
    start_op(64'd7, 64'd9);
    repeat (29) @(posedge clk);
    do_clear();
    saw = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (op_done) saw = 1'b1;
    end
    chk("abort_no_done", {127'b0, saw}, '0);
    run_op("p3x4", 64'd3, 64'd4, 128'd12);
    do_clear();

    // Start requests during EXEC and DONE are ignored.
    start_op(64'd11, 64'd13);
    repeat (10) @(posedge clk);
    start_op(64'd99, 64'd99);
    wait_done(n);
    chk("ign_exec_latency", 128'(n), 128'd53);
    chk("ign_exec_result", result, 128'd143);
    start_op(64'd50, 64'd50);
    repeat (5) @(posedge clk);
    #1;
    chk("ign_done_result", result, 128'd143);
    chk("ign_done_done", {127'b0, op_done}, 128'd1);
    do_clear();

    // start + clear together in IDLE stays idle.
    @(negedge clk);
    a = 64'd8; b = 64'd8; op_start = 1'b1; op_clear = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0; op_clear = 1'b0;
    saw = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      if (op_done) saw = 1'b1;
    end
    chk("start_clear_idle", {127'b0, saw}, '0);
    chk("start_clear_result", result, '0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
